// File: rtl/stream_mux_pkg.sv
// Shared types and constants for the stream multiplexer and its arbiter.
package stream_mux_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_e;

    localparam int MODE_FIXED = 0;
    localparam int MODE_RR    = 1;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational grant selection: fixed priority (lowest index) or round-robin from ptr.
module rr_arbiter
    import stream_mux_pkg::*;
#(
    parameter  int NCH  = 4,
    parameter  int MODE = MODE_FIXED,
    localparam int SELW = $clog2(NCH)
) (
    input  logic [NCH-1:0]  req,
    input  logic [SELW-1:0] ptr,
    output logic [SELW-1:0] grant_idx,
    output logic            grant_vld
);

    logic [SELW-1:0] idx;

    // Channel examined at scan position i; round-robin starts at ptr and wraps modulo NCH.
    function automatic int unsigned scan_idx(input int unsigned i, input logic [SELW-1:0] p);
        if (MODE == MODE_RR) begin
            return (int'(p) + i) % NCH;
        end
        return i;
    endfunction

    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        idx       = '0;
        for (int i = 0; i < NCH; i++) begin
            idx = SELW'(scan_idx(i, ptr));
            if (!grant_vld && req[idx]) begin
                grant_vld = 1'b1;
                grant_idx = idx;
            end
        end
    end

endmodule

// File: rtl/stream_mux.sv
// N-to-1 packet stream multiplexer with per-packet channel lock and a one-deep output register.
module stream_mux
    import stream_mux_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int NCH   = 4,
    parameter  int MODE  = MODE_FIXED,
    localparam int SELW  = $clog2(NCH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCH*WIDTH-1:0] in_data,
    input  logic [NCH-1:0]       in_valid,
    input  logic [NCH-1:0]       in_last,
    output logic [NCH-1:0]       in_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_valid,
    output logic                 out_last,
    output logic [SELW-1:0]      out_sel,
    input  logic                 out_ready
);

    state_e          state_q, state_d;
    logic [SELW-1:0] lock_q, lock_d;
    logic [SELW-1:0] rr_ptr_q, rr_ptr_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic            valid_q, valid_d;
    logic            last_q, last_d;
    logic [SELW-1:0] sel_q, sel_d;

    logic [SELW-1:0] arb_idx, gnt_idx;
    logic            arb_vld, gnt_vld;
    logic            can_accept, xfer, gnt_last;
    logic [WIDTH-1:0] gnt_data;

    function automatic logic [SELW-1:0] next_ptr(input logic [SELW-1:0] cur);
        return (cur == SELW'(NCH - 1)) ? '0 : cur + 1'b1;
    endfunction

    rr_arbiter #(
        .NCH  (NCH),
        .MODE (MODE)
    ) u_arb (
        .req       (in_valid),
        .ptr       (rr_ptr_q),
        .grant_idx (arb_idx),
        .grant_vld (arb_vld)
    );

    // Ready is derived only from grant, output occupancy and reset, never from payload.
    always_comb begin
        gnt_idx    = (state_q == LOCKED) ? lock_q : arb_idx;
        gnt_vld    = (state_q == LOCKED) || arb_vld;
        can_accept = !valid_q || out_ready;
        in_ready   = '0;
        if (gnt_vld && can_accept && !rst) begin
            in_ready[gnt_idx] = 1'b1;
        end
        xfer     = |(in_valid & in_ready);
        gnt_data = in_data[gnt_idx*WIDTH +: WIDTH];
        gnt_last = in_last[gnt_idx];
    end

    always_comb begin
        state_d  = state_q;
        lock_d   = lock_q;
        rr_ptr_d = rr_ptr_q;
        valid_d  = valid_q;
        data_d   = data_q;
        last_d   = last_q;
        sel_d    = sel_q;
        if (can_accept) begin
            valid_d = xfer;
        end
        if (xfer) begin
            data_d = gnt_data;
            last_d = gnt_last;
            sel_d  = gnt_idx;
            if (gnt_last) begin
                state_d = IDLE;
                if (MODE == MODE_RR) begin
                    rr_ptr_d = next_ptr(gnt_idx);
                end
            end else begin
                state_d = LOCKED;
                lock_d  = gnt_idx;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            lock_q   <= '0;
            rr_ptr_q <= '0;
            valid_q  <= 1'b0;
            data_q   <= '0;
            last_q   <= 1'b0;
            sel_q    <= '0;
        end else begin
            state_q  <= state_d;
            lock_q   <= lock_d;
            rr_ptr_q <= rr_ptr_d;
            valid_q  <= valid_d;
            data_q   <= data_d;
            last_q   <= last_d;
            sel_q    <= sel_d;
        end
    end

    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign out_last  = last_q;
    assign out_sel   = sel_q;

endmodule

// File: tb/tb_stream_mux.sv
// Directed scenarios on fixed-priority and round-robin instances, plus a randomized scoreboard run.
module tb_stream_mux;

    logic clk, rst;

    logic [31:0] a_data;  logic [3:0] a_valid, a_last, a_ready;
    logic [7:0]  a_odata; logic a_ovalid, a_olast, a_oready; logic [1:0] a_osel;
    logic [31:0] b_data;  logic [3:0] b_valid, b_last, b_ready;
    logic [7:0]  b_odata; logic b_ovalid, b_olast, b_oready; logic [1:0] b_osel;
    logic [31:0] c_data;  logic [1:0] c_valid, c_last, c_ready;
    logic [15:0] c_odata; logic c_ovalid, c_olast, c_oready; logic [0:0] c_osel;

    int checks = 0;
    int errors = 0;

    stream_mux #(.WIDTH(8), .NCH(4), .MODE(0)) dut_fix (
        .clk(clk), .rst(rst), .in_data(a_data), .in_valid(a_valid), .in_last(a_last),
        .in_ready(a_ready), .out_data(a_odata), .out_valid(a_ovalid), .out_last(a_olast),
        .out_sel(a_osel), .out_ready(a_oready));

    stream_mux #(.WIDTH(8), .NCH(4), .MODE(1)) dut_rr (
        .clk(clk), .rst(rst), .in_data(b_data), .in_valid(b_valid), .in_last(b_last),
        .in_ready(b_ready), .out_data(b_odata), .out_valid(b_ovalid), .out_last(b_olast),
        .out_sel(b_osel), .out_ready(b_oready));

    stream_mux #(.WIDTH(16), .NCH(2), .MODE(1)) dut_rnd (
        .clk(clk), .rst(rst), .in_data(c_data), .in_valid(c_valid), .in_last(c_last),
        .in_ready(c_ready), .out_data(c_odata), .out_valid(c_ovalid), .out_last(c_olast),
        .out_sel(c_osel), .out_ready(c_oready));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model state for the randomized run
    int          mlock, mptr, open_ch, g;
    logic        mvalid, gv, can, mx;
    logic [1:0]  exp_rdy, acc;
    logic [16:0] sq0[$], sq1[$];
    logic [16:0] beat;

    initial begin
        rst = 1'b1;
        a_data = '0; a_valid = 4'b1111; a_last = '0; a_oready = 1'b1;
        b_data = '0; b_valid = '0; b_last = '0; b_oready = 1'b1;
        c_data = '0; c_valid = '0; c_last = '0; c_oready = 1'b1;
        tick();
        tick();
        chk("rst_ready", a_ready, 4'b0000);
        chk("rst_ovalid", a_ovalid, 1'b0);
        chk("rst_odata", a_odata, 8'h00);
        chk("rst_osel", a_osel, 2'd0);
        chk("rst_olast", a_olast, 1'b0);

        // Scenario 1: fixed priority, two single-beat packets
        rst = 1'b0;
        a_valid = 4'b0101; a_last = 4'b1111; a_data = {8'h00, 8'h22, 8'h00, 8'h11};
        #1 chk("s1_ready0", a_ready, 4'b0001);
        tick();
        chk("s1_ovalid0", a_ovalid, 1'b1);
        chk("s1_data0", a_odata, 8'h11);
        chk("s1_sel0", a_osel, 2'd0);
        a_valid = 4'b0100;
        #1 chk("s1_ready1", a_ready, 4'b0100);
        tick();
        chk("s1_data1", a_odata, 8'h22);
        chk("s1_sel1", a_osel, 2'd2);
        chk("s1_ovalid1", a_ovalid, 1'b1);
        a_valid = 4'b0000;
        tick();
        chk("s1_idle", a_ovalid, 1'b0);

        // Scenario 2: round-robin, all channels always requesting
        b_valid = 4'b1111; b_last = 4'b1111; b_data = {8'h33, 8'h32, 8'h31, 8'h30};
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("s2_ovalid", b_ovalid, 1'b1);
            chk("s2_sel", b_osel, i % 4);
            chk("s2_data", b_odata, 8'h30 + (i % 4));
        end
        b_valid = 4'b0000;
        tick();
        chk("s2_idle", b_ovalid, 1'b0);

        // Scenario 3: ch1 three-beat packet holds off ch0
        a_valid = 4'b0010; a_last = 4'b0000; a_data = {8'h00, 8'h00, 8'hA0, 8'h00};
        #1 chk("s3_ready0", a_ready, 4'b0010);
        tick();
        chk("s3_d0", a_odata, 8'hA0);
        chk("s3_l0", a_olast, 1'b0);
        a_valid = 4'b0011; a_last = 4'b0001; a_data = {8'h00, 8'h00, 8'hA1, 8'h05};
        #1 chk("s3_ready1", a_ready, 4'b0010);
        tick();
        chk("s3_d1", a_odata, 8'hA1);
        chk("s3_l1", a_olast, 1'b0);
        a_valid = 4'b0001;
        #1 chk("s3_lock_novalid", a_ready, 4'b0010);
        tick();
        chk("s3_gap", a_ovalid, 1'b0);
        a_valid = 4'b0011; a_last = 4'b0011; a_data = {8'h00, 8'h00, 8'hA2, 8'h05};
        #1 chk("s3_ready2", a_ready, 4'b0010);
        tick();
        chk("s3_d2", a_odata, 8'hA2);
        chk("s3_l2", a_olast, 1'b1);
        chk("s3_s2", a_osel, 2'd1);
        a_valid = 4'b0001;
        #1 chk("s3_ready3", a_ready, 4'b0001);
        tick();
        chk("s3_ch0", a_odata, 8'h05);
        chk("s3_ch0sel", a_osel, 2'd0);
        a_valid = 4'b0000;
        tick();

        // Scenario 4: output backpressure for five cycles
        a_valid = 4'b0100; a_last = 4'b0100; a_data = {8'h00, 8'h40, 8'h00, 8'h00};
        tick();
        chk("s4_first", a_odata, 8'h40);
        a_data = {8'h00, 8'h41, 8'h00, 8'h00}; a_oready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1 chk("s4_hold_ready", a_ready, 4'b0000);
            tick();
            chk("s4_hold_data", a_odata, 8'h40);
            chk("s4_hold_valid", a_ovalid, 1'b1);
        end
        a_oready = 1'b1;
        #1 chk("s4_rel_ready", a_ready, 4'b0100);
        tick();
        chk("s4_next", a_odata, 8'h41);
        a_data = {8'h00, 8'h42, 8'h00, 8'h00};
        tick();
        chk("s4_next2", a_odata, 8'h42);
        a_valid = 4'b0000;
        tick();
        chk("s4_empty", a_ovalid, 1'b0);

        // Scenario 5: reset while locked on ch3
        b_valid = 4'b1000; b_last = 4'b0000; b_data = {8'hC0, 8'h00, 8'h00, 8'h00};
        #1 chk("s5_ready3", b_ready, 4'b1000);
        tick();
        chk("s5_c0", b_odata, 8'hC0);
        b_valid = 4'b1001; b_last = 4'b0001; b_data = {8'hC1, 8'h00, 8'h00, 8'hD0};
        #1 chk("s5_locked", b_ready, 4'b1000);
        rst = 1'b1;
        #1;
        chk("s5_rst_ovalid", b_ovalid, 1'b0);
        chk("s5_rst_ready", b_ready, 4'b0000);
        tick();
        chk("s5_rst_hold", b_ovalid, 1'b0);
        rst = 1'b0;
        b_last = 4'b1001;
        #1 chk("s5_ptr0", b_ready, 4'b0001);
        tick();
        chk("s5_win_sel", b_osel, 2'd0);
        chk("s5_win_data", b_odata, 8'hD0);
        b_valid = 4'b0000;
        tick();

        // Scenario 6: randomized two-channel round-robin against a scoreboard
        rst = 1'b1;
        tick();
        rst = 1'b0;
        mlock = -1; mptr = 0; mvalid = 1'b0; open_ch = -1;
        for (int cyc = 0; cyc < 10010; cyc++) begin
            #1;
            gv = 1'b0; g = 0;
            if (mlock >= 0) begin
                gv = 1'b1; g = mlock;
            end else begin
                for (int i = 0; i < 2; i++) begin
                    if (!gv && c_valid[(mptr + i) % 2]) begin
                        gv = 1'b1; g = (mptr + i) % 2;
                    end
                end
            end
            can = !mvalid || c_oready;
            exp_rdy = '0;
            if (gv && can) exp_rdy[g] = 1'b1;
            chk("s6_ready", c_ready, exp_rdy);
            chk("s6_ovalid", c_ovalid, mvalid);
            if (c_ovalid && c_oready) begin
                if (open_ch >= 0) chk("s6_nointerleave", c_osel, open_ch);
                chk("s6_qnonempty", ((c_osel == 1'b1) ? sq1.size() : sq0.size()) != 0, 1);
                if (c_osel == 1'b1 && sq1.size() != 0) begin
                    beat = sq1.pop_front();
                    chk("s6_beat_ch1", {c_olast, c_odata}, beat);
                end else if (c_osel == 1'b0 && sq0.size() != 0) begin
                    beat = sq0.pop_front();
                    chk("s6_beat_ch0", {c_olast, c_odata}, beat);
                end
                open_ch = c_olast ? -1 : int'(c_osel);
            end
            acc = c_valid & c_ready;
            if (acc[0]) sq0.push_back({c_last[0], c_data[15:0]});
            if (acc[1]) sq1.push_back({c_last[1], c_data[31:16]});
            mx = gv && can && c_valid[g];
            if (mx) begin
                if (c_last[g]) begin
                    mlock = -1; mptr = (g + 1) % 2;
                end else begin
                    mlock = g;
                end
            end
            if (can) mvalid = mx;
            tick();
            for (int k = 0; k < 2; k++) begin
                if (!c_valid[k] || acc[k]) begin
                    if (cyc < 10000 && ($urandom % 2) == 1) begin
                        c_valid[k] = 1'b1;
                        c_data[k*16 +: 16] = 16'($urandom);
                        c_last[k] = (($urandom % 3) == 0);
                    end else begin
                        c_valid[k] = 1'b0;
                    end
                end
            end
            c_oready = (cyc >= 10000) ? 1'b1 : (($urandom % 4) != 0);
        end
        chk("s6_drain_ch0", sq0.size(), 0);
        chk("s6_drain_ch1", sq1.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
